// File: rtl/trig_capture_if.sv
// trig_capture_if
//   AXI4-Stream style handshake bundle used for both the sample input and the
//   frame output of trig_capture.
//   Signals: tvalid, tready, tdata[DATA_W], tlast.
//   master: drives tvalid/tdata/tlast, receives tready.
//   slave : receives tvalid/tdata/tlast, drives tready.
interface trig_capture_if #(
    parameter int DATA_W = 8
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, tdata, tlast, input tready);
    modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/trig_capture.sv
// trig_capture
//   Circular sample recorder between the ADC stream and the SPI stream. After
//   arm it records cfg_pretrig samples, waits for a trigger (external edge,
//   level rising/falling, or forced), records the remaining post-trigger
//   samples, then replays the DEPTH-sample frame as one packet with tlast on
//   the final beat.
// Ports:
//   axis_aclk, axis_aresetn : clock, synchronous active-low reset
//   arm, abort              : start capture (IDLE only) / return to IDLE
//   cfg_src, cfg_trig_sel, cfg_level, cfg_pretrig : captured on arm
//   triggers                : asynchronous external trigger lines
//   s_axis (slave)          : sample input, tlast ignored
//   m_axis (master)         : frame output
//   busy, triggered         : status
module trig_capture #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 10,
    parameter int NUM_TRIG   = 2,
    localparam int SEL_W     = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [1:0]            cfg_src,
    input  logic [SEL_W-1:0]      cfg_trig_sel,
    input  logic [DATA_W-1:0]     cfg_level,
    input  logic [DEPTH_LOG2-1:0] cfg_pretrig,
    input  logic [NUM_TRIG-1:0]   triggers,
    trig_capture_if.slave         s_axis,
    trig_capture_if.master        m_axis,
    output logic                  busy,
    output logic                  triggered
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int NSEL  = 1 << SEL_W;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = DEPTH_LOG2'(0) + (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DRAIN} state_t;

    state_t                state;
    logic [1:0]            src_r;
    logic [SEL_W-1:0]      sel_r;
    logic [DATA_W-1:0]     level_r;
    logic [DEPTH_LOG2-1:0] pretrig_r;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [DEPTH_LOG2:0]   cnt;      // FILL: samples written; POST: post-samples written
    logic [DEPTH_LOG2:0]   rd_cnt;   // beats issued in DRAIN
    logic                  pend;
    logic [DATA_W-1:0]     prev;
    logic                  prev_ok;
    logic [NUM_TRIG-1:0]   sync1, sync2, sync3;
    logic                  s_ready;
    logic                  m_valid;
    logic                  m_last;
    logic [DATA_W-1:0]     m_data;
    logic                  trig_r;

    logic [DATA_W-1:0]     mem [DEPTH];

    logic                  accept;
    logic                  wr_en;
    logic [NSEL-1:0]       edge_pad;
    logic                  ext_edge;
    logic                  trig_hit;
    logic [DEPTH_LOG2:0]   post_need;
    logic [DATA_W-1:0]     cur;
    wire                   unused_tlast = s_axis.tlast;

    assign cur       = s_axis.tdata;
    assign accept    = s_axis.tvalid && s_ready;
    assign wr_en     = accept && !abort && (state == FILL || state == ARMED || state == POST);
    // Zero-pad so an out-of-range select simply never fires.
    assign edge_pad  = NSEL'(sync2 & ~sync3);
    assign ext_edge  = edge_pad[sel_r];
    assign post_need = DEPTH_C - {1'b0, pretrig_r};

    always_comb begin
        trig_hit = 1'b0;
        case (src_r)
            2'd0: trig_hit = pend || ext_edge;
            2'd1: trig_hit = prev_ok && (prev <  level_r) && (cur >= level_r);
            2'd2: trig_hit = prev_ok && (prev >= level_r) && (cur <  level_r);
            default: trig_hit = 1'b1;
        endcase
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = m_data;
    assign m_axis.tlast  = m_last;
    assign busy          = (state != IDLE);
    assign triggered     = trig_r;

    // Sample memory has no reset; only written while recording.
    always_ff @(posedge axis_aclk) begin
        if (wr_en) mem[wr_ptr] <= cur;
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            state     <= IDLE;
            src_r     <= '0;
            sel_r     <= '0;
            level_r   <= '0;
            pretrig_r <= '0;
            wr_ptr    <= '0;
            rd_addr   <= '0;
            cnt       <= '0;
            rd_cnt    <= '0;
            pend      <= 1'b0;
            prev      <= '0;
            prev_ok   <= 1'b0;
            sync1     <= '0;
            sync2     <= '0;
            sync3     <= '0;
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_data    <= '0;
            trig_r    <= 1'b0;
        end else begin
            s_ready <= 1'b1;
            sync1   <= triggers;
            sync2   <= sync1;
            sync3   <= sync2;
            if (ext_edge) pend <= 1'b1;

            if (abort) begin
                state   <= IDLE;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                trig_r  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (arm) begin
                        src_r     <= cfg_src;
                        sel_r     <= cfg_trig_sel;
                        level_r   <= cfg_level;
                        pretrig_r <= cfg_pretrig;
                        wr_ptr    <= '0;
                        cnt       <= '0;
                        rd_cnt    <= '0;
                        if (cfg_pretrig == '0) begin
                            state   <= ARMED;
                            pend    <= 1'b0;
                            prev_ok <= 1'b0;
                        end else begin
                            state <= FILL;
                        end
                    end
                    FILL: if (accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        cnt    <= cnt + 1'b1;
                        if (cnt + 1'b1 == {1'b0, pretrig_r}) begin
                            state   <= ARMED;
                            pend    <= 1'b0;
                            prev_ok <= 1'b0;
                        end
                    end
                    ARMED: if (accept) begin
                        wr_ptr  <= wr_ptr + 1'b1;
                        prev    <= cur;
                        prev_ok <= 1'b1;
                        if (trig_hit) begin
                            // Frame starts cfg_pretrig samples before the trigger address.
                            rd_addr <= wr_ptr - pretrig_r;
                            trig_r  <= 1'b1;
                            cnt     <= {{DEPTH_LOG2{1'b0}}, 1'b1};
                            rd_cnt  <= '0;
                            state   <= (post_need == {{DEPTH_LOG2{1'b0}}, 1'b1}) ? DRAIN : POST;
                        end
                    end
                    POST: if (accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        cnt    <= cnt + 1'b1;
                        if (cnt + 1'b1 == post_need) state <= DRAIN;
                    end
                    DRAIN: begin
                        // Output register doubles as the 1-cycle memory read stage.
                        if (!m_valid || m_axis.tready) begin
                            if (rd_cnt != DEPTH_C) begin
                                m_data  <= mem[rd_addr];
                                m_valid <= 1'b1;
                                m_last  <= (rd_cnt == DEPTH_C - 1'b1);
                                rd_addr <= rd_addr + 1'b1;
                                rd_cnt  <= rd_cnt + 1'b1;
                            end else begin
                                m_valid <= 1'b0;
                                m_last  <= 1'b0;
                            end
                        end
                        if (m_valid && m_axis.tready && m_last) begin
                            state   <= IDLE;
                            trig_r  <= 1'b0;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trig_capture.sv
// tb_trig_capture
//   Directed bench for trig_capture with DEPTH_LOG2=4. Expected frames are
//   queued when each scenario is set up; a monitor collects output beats and
//   checks data/tlast stability across stalls.
module tb_trig_capture;
    localparam int DW = 8;
    localparam int DL = 4;
    localparam int NT = 2;
    localparam int N  = 1 << DL;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    cfg_src = '0;
    logic          cfg_trig_sel = 1'b0;
    logic [DW-1:0] cfg_level = '0;
    logic [DL-1:0] cfg_pretrig = '0;
    logic [NT-1:0] triggers = '0;
    logic          busy, triggered;

    int checks = 0;
    int failures = 0;

    beat_t exp_q[$];
    beat_t got[$];

    trig_capture_if #(.DATA_W(DW)) s_if ();
    trig_capture_if #(.DATA_W(DW)) m_if ();

    trig_capture #(.DATA_W(DW), .DEPTH_LOG2(DL), .NUM_TRIG(NT)) dut (
        .axis_aclk    (clk),
        .axis_aresetn (rstn),
        .arm          (arm),
        .abort        (abort),
        .cfg_src      (cfg_src),
        .cfg_trig_sel (cfg_trig_sel),
        .cfg_level    (cfg_level),
        .cfg_pretrig  (cfg_pretrig),
        .triggers     (triggers),
        .s_axis       (s_if.slave),
        .m_axis       (m_if.master),
        .busy         (busy),
        .triggered    (triggered)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, between driving edges.
    initial begin
        logic          held_v;
        logic [DW-1:0] held_d;
        logic          held_l;
        held_v = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && m_if.tvalid) begin
                if (held_v) begin
                    chk("stall_data", 32'(m_if.tdata), 32'(held_d));
                    chk("stall_last", 32'(m_if.tlast), 32'(held_l));
                end
                if (m_if.tready) begin
                    got.push_back('{m_if.tdata, m_if.tlast});
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held_d = m_if.tdata;
                    held_l = m_if.tlast;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic push_ramp(input logic [DW-1:0] first);
        for (int i = 0; i < N; i++) exp_q.push_back('{DW'(first + DW'(i)), (i == N - 1)});
    endtask

    task automatic do_arm(input logic [1:0] src, input logic sel, input logic [DW-1:0] lvl,
                          input logic [DL-1:0] pre);
        s_if.tvalid  = 1'b0;
        arm          = 1'b1;
        cfg_src      = src;
        cfg_trig_sel = sel;
        cfg_level    = lvl;
        cfg_pretrig  = pre;
        @(posedge clk); #1;
        arm = 1'b0;
        chk("busy_after_arm", 32'(busy), 32'd1);
    endtask

    // Drive a ramp until the frame ends (busy falls), a reset point is reached,
    // or the cycle budget runs out.
    task automatic run(input logic [DW-1:0] start, input bit rnd, input int rst_beat,
                       input int trig_val, input int ext0_at, input int ext1_at);
        logic [DW-1:0] v;
        bit done;
        v = start;
        done = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = v;
            m_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (int'(v) == ext0_at) triggers[0] = 1'b1;
            if (int'(v) == ext1_at) triggers[1] = 1'b1;
            @(posedge clk); #1;
            if (int'(v) == trig_val - 1) chk("triggered_before", 32'(triggered), 32'd0);
            if (int'(v) == trig_val)     chk("triggered_at", 32'(triggered), 32'd1);
            v++;
            if (rst_beat > 0 && got.size() >= rst_beat) begin
                rstn = 1'b0;
                @(posedge clk); #1;
                chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
                chk("rst_tlast", 32'(m_if.tlast), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_tready", 32'(s_if.tready), 32'd0);
                rstn = 1'b1;
                done = 1'b1;
            end else if (!busy) begin
                done = 1'b1;
            end
        end
        chk("frame_done", 32'(done), 32'd1);
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b0;
        triggers    = '0;
    endtask

    task automatic check_frame(input string tag);
        beat_t e;
        chk({tag, "_beats"}, 32'(got.size()), 32'(N));
        for (int i = 0; i < N; i++) begin
            e = exp_q.pop_front();
            if (i < got.size()) begin
                chk({tag, "_data"}, 32'(got[i].d), 32'(e.d));
                chk({tag, "_last"}, 32'(got[i].l), 32'(e.l));
            end
        end
        got.delete();
        exp_q.delete();
        chk({tag, "_idle_triggered"}, 32'(triggered), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] f;
        int fi;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_if.tlast), 32'd0);
        chk("rst_m_tdata", 32'(m_if.tdata), 32'd0);
        chk("rst_s_tready", 32'(s_if.tready), 32'd0);
        chk("rst_busy0", 32'(busy), 32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("s_tready_up", 32'(s_if.tready), 32'd1);

        // Level rising, 4 pre-trigger samples: 0x7C..0x8B
        push_ramp(8'h7C);
        do_arm(2'd1, 1'b0, 8'h80, 4'd4);
        run(8'h00, 1'b0, 0, 'h80, -1, -1);
        check_frame("lvl_rise");

        // External edge on line 1; an earlier edge on line 0 must be ignored
        do_arm(2'd0, 1'b1, 8'h00, 4'd0);
        run(8'h00, 1'b0, 0, -1, 'h08, 'h20);
        chk("ext_beats", 32'(got.size()), 32'(N));
        if (got.size() == N) begin
            f  = got[0].d;
            fi = int'(f);
            chk("ext_first_window", 32'(fi >= 'h22 && fi <= 'h23), 32'd1);
            for (int i = 1; i < N; i++) chk("ext_consec", 32'(got[i].d), 32'(DW'(f + DW'(i))));
            for (int i = 0; i < N; i++) chk("ext_last", 32'(got[i].l), 32'(i == N - 1));
        end
        got.delete();

        // Forced trigger with maximal pre-trigger: 0x10..0x1F
        push_ramp(8'h10);
        do_arm(2'd3, 1'b0, 8'h00, 4'd15);
        run(8'h10, 1'b0, 0, -1, -1, -1);
        check_frame("force");

        // Level rising with random output stalls: 0x4A..0x59
        push_ramp(8'h4A);
        do_arm(2'd1, 1'b0, 8'h50, 4'd6);
        run(8'h40, 1'b1, 0, 'h50, -1, -1);
        check_frame("stall");

        // Falling below 0 can never happen: stays ARMED until abort
        do_arm(2'd2, 1'b0, 8'h00, 4'd2);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h40;
        repeat (30) @(posedge clk);
        #1;
        chk("stuck_busy", 32'(busy), 32'd1);
        chk("stuck_triggered", 32'(triggered), 32'd0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        s_if.tvalid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tvalid", 32'(m_if.tvalid), 32'd0);
        push_ramp(8'h90);
        do_arm(2'd3, 1'b0, 8'h00, 4'd0);
        run(8'h90, 1'b0, 0, -1, -1, -1);
        check_frame("after_abort");

        // Reset during DRAIN at beat 5, then a full frame
        do_arm(2'd1, 1'b0, 8'h80, 4'd4);
        run(8'h00, 1'b0, 5, -1, -1, -1);
        got.delete();
        @(posedge clk); #1;
        push_ramp(8'h7C);
        do_arm(2'd1, 1'b0, 8'h80, 4'd4);
        run(8'h00, 1'b0, 0, -1, -1, -1);
        check_frame("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trig_capture.md
# trig_capture

Parametrised trigger-and-capture buffer between the ADC sample stream and the SPI send stream. It holds a circular record of incoming samples and stops on a trigger: an external trigger line, a level crossing, or a forced trigger. It then stores a configurable number of pre-trigger samples plus the trigger and post-trigger samples. The frame is replayed in order as one AXI4-Stream packet with tlast on the final beat.

## Interface
Parameters:
- DATA_W, 8: sample width.
- DEPTH_LOG2, 10: buffer depth is DEPTH = 2^DEPTH_LOG2 samples, which is also the frame length.
- NUM_TRIG, 2: number of external trigger inputs. Must be ≥ 1.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_aresetn  in  1  synchronous active-low reset.
- arm  in  1  single-cycle pulse; starts a capture when in IDLE; ignored otherwise.
- abort  in  1  returns the block to IDLE from any state.
- cfg_src  in  2  trigger source, sampled on arm: 0 = external edge, 1 = level rising, 2 = level falling, 3 = force.
- cfg_trig_sel  in  max(1,$clog2(NUM_TRIG))  external trigger index, sampled on arm.
- cfg_level  in  DATA_W  level threshold (unsigned), sampled on arm.
- cfg_pretrig  in  DEPTH_LOG2  number of pre-trigger samples (0..DEPTH-1), sampled on arm.
- triggers  in  NUM_TRIG  asynchronous external triggers.
- s_axis_tvalid / s_axis_tready / s_axis_tdata[DATA_W] / s_axis_tlast  sample input; tlast is ignored.
- m_axis_tvalid / m_axis_tready / m_axis_tdata[DATA_W] / m_axis_tlast  frame output.
- busy  out  1  high in any state other than IDLE.
- triggered  out  1  high from the trigger sample until the return to IDLE.

## Operation
- States: IDLE, FILL, ARMED, POST, DRAIN.
- A sample is accepted on s_axis_tvalid && s_axis_tready.
- s_axis_tready is 1 in every state except reset. Samples accepted in IDLE or DRAIN are discarded.
- IDLE→FILL on arm when cfg_pretrig > 0. IDLE→ARMED on arm when cfg_pretrig = 0. The write pointer resets to 0 on arm.
- FILL writes accepted samples. Move to ARMED after cfg_pretrig samples have been written. Triggers are not evaluated in FILL.
- ARMED writes accepted samples circularly (pointer wraps modulo DEPTH) and evaluates the trigger on each accepted sample:
  - src 0: the triggers line is synchronised by 2 flops, then rising-edge detected. An edge sets a pending flag. The flag is cleared on entry to ARMED. The first accepted sample with the pending flag set, or with an edge detected in that same cycle, is the trigger sample.
  - src 1: prev < cfg_level && cur ≥ cfg_level. src 2: prev ≥ cfg_level && cur < cfg_level. prev is the previous sample accepted in ARMED; the first sample in ARMED never triggers.
  - src 3: the first accepted sample in ARMED triggers.
- On the trigger sample:
  - It is written at address T.
  - Record the start address S = (T − cfg_pretrig) mod DEPTH.
  - Set triggered and go to POST.
  - This sample counts as post-sample 1.
- POST writes samples until DEPTH − cfg_pretrig post-samples have been written (trigger sample included), then goes to DRAIN.
- DRAIN reads addresses S, S+1, … (mod DEPTH) for exactly DEPTH beats. m_axis_tlast is asserted on beat DEPTH. After that beat completes its handshake, go to IDLE.
- abort: go to IDLE on the next edge. m_axis_tvalid, busy and triggered drop at that edge, even mid-packet.
- arm and abort in the same cycle: abort wins.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, busy=0, triggered=0, state IDLE, pending flag 0, synchroniser flops 0.
- busy rises in the cycle after arm.
- External trigger latency: a triggers edge affects the sample accepted 3 cycles later at the earliest (2 sync flops plus the edge register).
- Buffer read latency is 1 cycle. First m_axis_tvalid asserts no later than 2 cycles after entering DRAIN.
- At full throughput (tready held high), one beat per cycle.
- m_axis_tdata and m_axis_tlast hold stable while tvalid && !tready. Once asserted, tvalid stays high until its handshake, except on abort or reset.
- busy and triggered fall on the cycle after the final beat's handshake.
- Reset mid-operation: all outputs take their reset values on the next edge, with no partial beats.

## Test plan
All scenarios use DEPTH_LOG2=4.
- pretrig=4, src=1, level=0x80, input ramp 0x00,0x01,… each cycle → output 0x7C..0x8B (16 beats), tlast on 0x8B, triggered high from sample 0x80.
- pretrig=0, src=0, sel=1, ramp input, single rising edge on triggers[1] → first beat is a sample accepted ≥3 cycles after the edge; 16 consecutive values follow; an edge on triggers[0] is ignored.
- src=3, pretrig=15, ramp starting at 0x10 → output 0x10..0x1F, tlast on 0x1F.
- src=1, random m_axis_tready (50%) → exactly 16 beats, in order, with tdata stable across stalls and one tlast.
- src=2, level=0x00, constant input 0x40 → block stays in ARMED with busy=1; abort → busy=0 and state IDLE next cycle; a fresh arm then works.
- Reset asserted at beat 5 of DRAIN → m_axis_tvalid=0 and busy=0 the next cycle; arm after reset produces a full, correct frame.
